mem_port_arbiter: RTL

- Shares the single cache port (address, write data, write enable, read strobe, ready, read data) between two requesters: instruction fetch (read-only) and the load/store data path.
- Arbitrates round-robin and holds each access until the cache reports ready.
- Latches read data and returns a one-cycle acknowledge to the winning requester.
- Flags accesses that exceed a cycle budget.

---
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one cache port between instruction fetch and the
// load/store path; holds each access until cache_ready or a cycle budget expires.
module mem_port_arbiter #(
  parameter int unsigned AW      = 10,
  parameter int unsigned DW      = 10,
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned CW      = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] cache_addr,
  output logic [DW-1:0] cache_wdata,
  output logic          cache_we,
  output logic          cache_rd,
  input  logic          cache_ready,
  input  logic [DW-1:0] cache_rdata,
  output logic          busy,
  output logic          timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          gnt_q, gnt_d;
  logic          lat_we_q, lat_we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] cache_addr_q, cache_addr_d;
  logic [DW-1:0] cache_wdata_q, cache_wdata_d;
  logic          cache_we_q, cache_we_d;
  logic          cache_rd_q, cache_rd_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          busy_q, busy_d;
  logic          timeout_err_q, timeout_err_d;
  logic          winner;
  logic          finish;

  // Next-state and registered-output computation
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    gnt_d         = gnt_q;
    lat_we_d      = lat_we_q;
    cnt_d         = cnt_q;
    cache_addr_d  = cache_addr_q;
    cache_wdata_d = cache_wdata_q;
    cache_we_d    = cache_we_q;
    cache_rd_d    = cache_rd_q;
    if_ack_d      = 1'b0;
    d_ack_d       = 1'b0;
    if_rdata_d    = if_rdata_q;
    d_rdata_d     = d_rdata_q;
    busy_d        = busy_q;
    timeout_err_d = timeout_err_q;
    winner        = last_grant_q;
    finish        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          // On a tie the requester that did not win last time goes first
          winner       = (if_req && d_req) ? ~last_grant_q : d_req;
          gnt_d        = winner;
          last_grant_d = winner;
          lat_we_d     = winner & d_we;
          cache_addr_d = (winner == GNT_DATA) ? d_addr : if_addr;
          if (winner == GNT_DATA) cache_wdata_d = d_wdata;
          cache_we_d   = winner & d_we;
          cache_rd_d   = ~(winner & d_we);
          busy_d       = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cache_ready) begin
          finish = 1'b1;
          if (!lat_we_q) begin
            if (gnt_q == GNT_DATA) d_rdata_d  = cache_rdata;
            else                   if_rdata_d = cache_rdata;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          finish        = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Completion (normal or abandoned) always acks so the requester never hangs
    if (finish) begin
      state_d    = S_DONE;
      cache_we_d = 1'b0;
      cache_rd_d = 1'b0;
      if_ack_d   = (gnt_q == GNT_FETCH);
      d_ack_d    = (gnt_q == GNT_DATA);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      last_grant_q  <= GNT_DATA;
      gnt_q         <= GNT_FETCH;
      lat_we_q      <= 1'b0;
      cnt_q         <= '0;
      cache_addr_q  <= '0;
      cache_wdata_q <= '0;
      cache_we_q    <= 1'b0;
      cache_rd_q    <= 1'b0;
      if_ack_q      <= 1'b0;
      d_ack_q       <= 1'b0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      gnt_q         <= gnt_d;
      lat_we_q      <= lat_we_d;
      cnt_q         <= cnt_d;
      cache_addr_q  <= cache_addr_d;
      cache_wdata_q <= cache_wdata_d;
      cache_we_q    <= cache_we_d;
      cache_rd_q    <= cache_rd_d;
      if_ack_q      <= if_ack_d;
      d_ack_q       <= d_ack_d;
      if_rdata_q    <= if_rdata_d;
      d_rdata_q     <= d_rdata_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign if_ack      = if_ack_q;
  assign d_ack       = d_ack_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign cache_addr  = cache_addr_q;
  assign cache_wdata = cache_wdata_q;
  assign cache_we    = cache_we_q;
  assign cache_rd    = cache_rd_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule
